// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: opcodes, control-bit positions,
// access sizes and the memory-dump state encoding.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int MEM_BRANCH = 2;
    localparam int MEM_WR     = 1;
    localparam int MEM_RD     = 0;

    localparam int WB_MEMTOREG = 1;
    localparam int WB_REGWRITE = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } dump_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    // Unknown opcodes fall back to a full-word access.
    function automatic acc_size_t op_size(input logic [5:0] op);
        acc_size_t sz;
        sz = SZ_WORD;
        unique case (1'b1)
            (op == OP_LB), (op == OP_LBU), (op == OP_SB): sz = SZ_BYTE;
            (op == OP_LH), (op == OP_LHU), (op == OP_SH): sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory: byte-lane write on the falling edge, two async read
// ports (pipeline access and memory dump).
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int MSB        = 31,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                    clk,
    input  logic [(MSB+1)/8-1:0]    we,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [MSB:0]            wdata,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    output logic [MSB:0]            rdata,
    input  logic [DEPTH_LOG2-1:0]   daddr,
    output logic [MSB:0]            ddata
);

    localparam int NB = (MSB + 1) / 8;

    logic [MSB:0] mem [2**DEPTH_LOG2];

    always_ff @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];
    assign ddata = mem[daddr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store alignment, MEM/WB register, and an
// optional memory-dump engine enabled by MEM_STAGE_DUMP_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MSB        = 31,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  db_ena,
    input  logic [MSB:0]          in_ALU,
    input  logic                  in_zero,
    input  logic [4:0]            in_addr_dest,
    input  logic [MSB:0]          in_wr_data,
    input  logic [2:0]            in_MEM,
    input  logic [1:0]            in_WB,
    input  logic [5:0]            in_opcode,
    input  logic                  in_PCend,
    output logic                  pc_src,
    output logic [MSB:0]          memwb_rd_data,
    output logic [MSB:0]          memwb_ALU,
    output logic [4:0]            memwb_addr_dest,
    output logic [1:0]            out_WB,
    output logic                  out_PCendMEM,
    output logic                  misalign,
    input  logic                  dump_req,
    output logic                  dump_busy,
    output logic                  dump_valid,
    output logic [DEPTH_LOG2-1:0] dump_addr,
    output logic [MSB:0]          dump_data
);

    localparam int NB = (MSB + 1) / 8;
    localparam int W  = DEPTH_LOG2;

    logic [W-1:0]  widx;
    logic [1:0]    off;
    acc_size_t     sz;
    logic          sgn;
    logic          is_rd;
    logic          is_wr;
    logic          mis_acc;
    logic          st_en;
    logic          dump_blk;
    logic [NB-1:0] we;
    logic [MSB:0]  wdata;
    logic [MSB:0]  rdata;
    logic [MSB:0]  lane;
    logic [MSB:0]  ld_val;
    logic [W-1:0]  daddr;
    logic [MSB:0]  ddata;
    logic          unused_alu_hi;

    assign widx  = in_ALU[W+1:2];
    assign off   = in_ALU[1:0];
    assign sz    = op_size(in_opcode);
    assign sgn   = op_signed(in_opcode);
    assign is_rd = in_MEM[MEM_RD];
    assign is_wr = in_MEM[MEM_WR];

    assign unused_alu_hi = |in_ALU[MSB:W+2];

    assign pc_src = in_MEM[MEM_BRANCH] & in_zero;

    assign mis_acc = ((sz == SZ_HALF) && off[0]) ||
                     ((sz == SZ_WORD) && (off != 2'b00));

    assign st_en = db_ena && is_wr && !mis_acc && !dump_blk;

    // Store data is replicated across lanes; the enables pick the lanes.
    always_comb begin
        we    = '0;
        wdata = in_wr_data;
        case (sz)
            SZ_BYTE: begin
                we[off] = st_en;
                wdata   = {NB{in_wr_data[7:0]}};
            end
            SZ_HALF: begin
                we[{off[1], 1'b0} +: 2] = {2{st_en}};
                wdata = {(NB/2){in_wr_data[15:0]}};
            end
            default: begin
                we = {NB{st_en}};
            end
        endcase
    end

    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        ld_val = rdata;
        case (sz)
            SZ_BYTE: ld_val = {{(MSB-7){sgn & lane[7]}}, lane[7:0]};
            SZ_HALF: ld_val = {{(MSB-15){sgn & lane[15]}}, lane[15:0]};
            default: ld_val = rdata;
        endcase
    end

    data_mem #(
        .MSB       (MSB),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(widx),
        .wdata(wdata),
        .raddr(widx),
        .rdata(rdata),
        .daddr(daddr),
        .ddata(ddata)
    );

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            memwb_rd_data   <= '0;
            memwb_ALU       <= '0;
            memwb_addr_dest <= '0;
            out_WB          <= '0;
            out_PCendMEM    <= 1'b0;
            misalign        <= 1'b0;
        end else if (db_ena) begin
            memwb_rd_data   <= (is_rd && !mis_acc) ? ld_val : '0;
            memwb_ALU       <= in_ALU;
            memwb_addr_dest <= in_addr_dest;
            out_WB          <= in_WB;
            out_PCendMEM    <= in_PCend;
            if ((is_rd || is_wr) && mis_acc) begin
                misalign <= 1'b1;
            end
        end
    end

`ifdef MEM_STAGE_DUMP_EN

    dump_state_t state;

    // Next word to present: restart at 0, else follow the last one shown.
    assign daddr    = dump_valid ? dump_addr + 1'b1 : '0;
    assign dump_blk = dump_busy;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dump_req) begin
                        state      <= ST_DUMP;
                        dump_addr  <= '0;
                        dump_busy  <= 1'b1;
                        dump_valid <= 1'b0;
                    end
                end
                ST_DUMP: begin
                    if (dump_valid && (dump_addr == '1)) begin
                        state      <= ST_DONE;
                        dump_valid <= 1'b0;
                        dump_busy  <= 1'b0;
                    end else begin
                        dump_addr  <= daddr;
                        dump_data  <= ddata;
                        dump_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!dump_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`else

    logic unused_dump;

    assign daddr       = '0;
    assign dump_blk    = 1'b0;
    assign dump_busy   = 1'b0;
    assign dump_valid  = 1'b0;
    assign dump_addr   = '0;
    assign dump_data   = '0;
    assign unused_dump = dump_req | (|ddata);

`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-array reference model, directed
// cases, dump/reset scenarios and randomized traffic.
module tb_mem_stage;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

`ifdef MEM_STAGE_DUMP_EN
    localparam bit DUMP_EN = 1'b1;
`else
    localparam bit DUMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        db_ena;
    logic [31:0] in_ALU;
    logic        in_zero;
    logic [4:0]  in_addr_dest;
    logic [31:0] in_wr_data;
    logic [2:0]  in_MEM;
    logic [1:0]  in_WB;
    logic [5:0]  in_opcode;
    logic        in_PCend;
    logic        pc_src;
    logic [31:0] memwb_rd_data;
    logic [31:0] memwb_ALU;
    logic [4:0]  memwb_addr_dest;
    logic [1:0]  out_WB;
    logic        out_PCendMEM;
    logic        misalign;
    logic        dump_req;
    logic        dump_busy;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    always #5 clk = ~clk;

    mem_stage #(.MSB(31), .DEPTH_LOG2(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .db_ena         (db_ena),
        .in_ALU         (in_ALU),
        .in_zero        (in_zero),
        .in_addr_dest   (in_addr_dest),
        .in_wr_data     (in_wr_data),
        .in_MEM         (in_MEM),
        .in_WB          (in_WB),
        .in_opcode      (in_opcode),
        .in_PCend       (in_PCend),
        .pc_src         (pc_src),
        .memwb_rd_data  (memwb_rd_data),
        .memwb_ALU      (memwb_ALU),
        .memwb_addr_dest(memwb_addr_dest),
        .out_WB         (out_WB),
        .out_PCendMEM   (out_PCendMEM),
        .misalign       (misalign),
        .dump_req       (dump_req),
        .dump_busy      (dump_busy),
        .dump_valid     (dump_valid),
        .dump_addr      (dump_addr),
        .dump_data      (dump_data)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic [1:0]  wb;
        logic        pce;
        logic        mis;
        logic        busy;
        logic        valid;
        logic [4:0]  daddr;
        logic [31:0] ddata;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [7:0] mb [128];
    int         dphase;
    bit         ddone;
    int         tests;
    int         fails;
    int         nvalid;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int acc_bytes(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mem_word(input int k);
        return {mb[4*k+3], mb[4*k+2], mb[4*k+1], mb[4*k]};
    endfunction

    // Byte-addressed little-endian view of memory; misaligned reads give 0.
    function automatic logic [31:0] ref_load(input logic [5:0] op,
                                             input logic [31:0] a);
        int n;
        int base;
        logic [31:0] v;
        n    = acc_bytes(op);
        base = int'(a[6:0]);
        v    = 32'h0;
        if (base % n != 0) return 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mb[base+i]) << (8*i));
        if (op == LB && v[7])  v = v | 32'hFFFFFF00;
        if (op == LH && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_edge(input bit en, input logic [2:0] m,
                              input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input bit dreq);
        int  n;
        int  base;
        bit  mis;
        bit  blocked;
        n       = acc_bytes(op);
        base    = int'(a[6:0]);
        mis     = (m[1] | m[0]) && (base % n != 0);
        blocked = (dphase > 0);
        if (en) begin
            cur.rd = m[0] ? ref_load(op, a) : 32'h0;
            if (m[1] && !mis && !blocked)
                for (int i = 0; i < n; i++)
                    mb[base+i] = 8'(wd >> (8*i));
            if (mis) cur.mis = 1'b1;
            cur.alu  = a;
            cur.dest = in_addr_dest;
            cur.wb   = in_WB;
            cur.pce  = in_PCend;
        end
        if (dphase == 0) begin
            if (ddone) begin
                if (!dreq) ddone = 1'b0;
            end else if (dreq && DUMP_EN) begin
                dphase     = 1;
                cur.busy   = 1'b1;
                cur.daddr  = 5'd0;
                cur.valid  = 1'b0;
            end
        end else if (dphase <= 32) begin
            cur.valid = 1'b1;
            cur.daddr = 5'(dphase - 1);
            cur.ddata = mem_word(dphase - 1);
            dphase++;
        end else begin
            cur.valid = 1'b0;
            cur.busy  = 1'b0;
            dphase    = 0;
            ddone     = 1'b1;
        end
        q.push_back(cur);
    endtask

    task automatic step(input bit en, input logic [2:0] m,
                        input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit dreq);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        db_ena       = en;
        in_MEM       = m;
        in_opcode    = op;
        in_ALU       = a;
        in_wr_data   = wd;
        dump_req     = dreq;
        in_WB        = 2'($urandom);
        in_addr_dest = 5'($urandom);
        in_PCend     = 1'($urandom);
        in_zero      = 1'($urandom);
        model_edge(en, m, op, a, wd, dreq);
        #1;
        chk("pc_src", 32'(pc_src), 32'(m[2] & in_zero));
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input bit dreq);
        step(1'b1, 3'b000, 6'h00, 32'($urandom), 32'h0, dreq);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_rd",    memwb_rd_data, 32'h0);
        chk("rst_alu",   memwb_ALU, 32'h0);
        chk("rst_dest",  32'(memwb_addr_dest), 32'h0);
        chk("rst_wb",    32'(out_WB), 32'h0);
        chk("rst_pce",   32'(out_PCendMEM), 32'h0);
        chk("rst_mis",   32'(misalign), 32'h0);
        chk("rst_busy",  32'(dump_busy), 32'h0);
        chk("rst_valid", 32'(dump_valid), 32'h0);
        chk("rst_daddr", 32'(dump_addr), 32'h0);
        chk("rst_ddata", dump_data, 32'h0);
        cur    = '{default: 0};
        dphase = 0;
        ddone  = 1'b0;
        q.push_back(cur);
        @(negedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data", memwb_rd_data, e.rd);
                chk("alu",     memwb_ALU, e.alu);
                chk("dest",    32'(memwb_addr_dest), 32'(e.dest));
                chk("wb",      32'(out_WB), 32'(e.wb));
                chk("pcend",   32'(out_PCendMEM), 32'(e.pce));
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("busy",    32'(dump_busy), 32'(e.busy));
                chk("valid",   32'(dump_valid), 32'(e.valid));
                chk("daddr",   32'(dump_addr), 32'(e.daddr));
                chk("ddata",   dump_data, e.ddata);
                if (dump_valid) nvalid++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          base;
        int          r;
        logic [5:0]  op;
        logic [2:0]  m;
        logic [31:0] a;
        tests        = 0;
        fails        = 0;
        nvalid       = 0;
        dphase       = 0;
        ddone        = 1'b0;
        cur          = '{default: 0};
        reset        = 1'b1;
        db_ena       = 1'b0;
        in_ALU       = 32'h0;
        in_zero      = 1'b0;
        in_addr_dest = 5'h0;
        in_wr_data   = 32'h0;
        in_MEM       = 3'b000;
        in_WB        = 2'b00;
        in_opcode    = 6'h00;
        in_PCend     = 1'b0;
        dump_req     = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        for (int w = 0; w < 32; w++)
            step(1'b1, 3'b010, SW, (32'($urandom) & 32'hFFFFFF80) | 32'(w*4),
                 32'($urandom), 1'b0);

        step(1'b1, 3'b010, SW, 32'h8, 32'h11223344, 1'b0);
        step(1'b1, 3'b001, LW, 32'h8, 32'h0, 1'b0);
        chk("lw_sw", memwb_rd_data, 32'h11223344);
        step(1'b1, 3'b010, SB, 32'h9, 32'h000000AB, 1'b0);
        step(1'b1, 3'b001, LB, 32'h9, 32'h0, 1'b0);
        chk("lb_sext", memwb_rd_data, 32'hFFFFFFAB);
        step(1'b1, 3'b001, LBU, 32'h9, 32'h0, 1'b0);
        chk("lbu_zext", memwb_rd_data, 32'h000000AB);
        step(1'b1, 3'b001, LW, 32'h8, 32'h0, 1'b0);
        chk("lw_after_sb", memwb_rd_data, 32'h1122AB44);
        chk("mis_clear", 32'(misalign), 32'h0);

        step(1'b1, 3'b010, SH, 32'h3, 32'h0000BEEF, 1'b0);
        chk("mis_set", 32'(misalign), 32'h1);
        step(1'b1, 3'b001, LW, 32'h2, 32'h0, 1'b0);
        chk("lw_mis_zero", memwb_rd_data, 32'h0);
        step(1'b1, 3'b001, LW, 32'h0, 32'h0, 1'b0);
        step(1'b1, 3'b001, LH, 32'h8, 32'h0, 1'b0);
        chk("lh_sext", memwb_rd_data, 32'hFFFFAB44);
        step(1'b1, 3'b001, LHU, 32'hA, 32'h0, 1'b0);
        chk("lhu_hi", memwb_rd_data, 32'h00001122);
        chk("mis_sticky", 32'(misalign), 32'h1);

        in_MEM  = 3'b100;
        in_zero = 1'b1;
        #1;
        chk("branch_taken", 32'(pc_src), 32'h1);
        in_zero = 1'b0;
        #1;
        chk("branch_not", 32'(pc_src), 32'h0);

        step(1'b1, 3'b001, LW, 32'h108, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 3'b001, LB, 32'($urandom), 32'h0, 1'b0);
        chk("hold_rd", memwb_rd_data, 32'h1122AB44);
        chk("hold_alu", memwb_ALU, 32'h108);

        nvalid = 0;
        idle(1'b1);
        for (int i = 0; i < 40; i++) begin
            if (i == 5)
                step(1'b1, 3'b010, SW, 32'h10, 32'hDEADBEEF, 1'b0);
            else
                idle(1'b0);
        end
        chk("dump_count", 32'(nvalid), DUMP_EN ? 32'd32 : 32'd0);
        step(1'b1, 3'b001, LW, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 80; i++) idle(1'b1);
        chk("held_no_retrig", 32'(nvalid), DUMP_EN ? 32'd64 : 32'd0);
        repeat (3) idle(1'b0);

        idle(1'b1);
        for (int i = 0; i < 11; i++) idle(1'b0);
        chk("dump_at10", 32'(dump_addr), DUMP_EN ? 32'd10 : 32'd0);
        do_reset();
        for (int w = 0; w < 32; w += 3)
            step(1'b1, 3'b001, LW, 32'(w*4), 32'h0, 1'b0);
        base = nvalid;
        idle(1'b1);
        for (int i = 0; i < 36; i++) idle(1'b0);
        chk("dump_after_rst", 32'(nvalid - base), DUMP_EN ? 32'd32 : 32'd0);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            a = 32'($urandom);
            if (r < 4) begin
                m = 3'b001;
                case ($urandom_range(0, 4))
                    0: op = LB;
                    1: op = LH;
                    2: op = LW;
                    3: op = LBU;
                    default: op = LHU;
                endcase
            end else if (r < 8) begin
                m = 3'b010;
                case ($urandom_range(0, 3))
                    0: op = SB;
                    1: op = SH;
                    2: op = SW;
                    default: op = 6'h3F;
                endcase
            end else begin
                m  = (r == 8) ? 3'b100 : 3'b000;
                op = 6'h00;
            end
            if ($urandom_range(0, 7) != 0)
                a = a & ~32'(acc_bytes(op) - 1);
            step($urandom_range(0, 9) != 0, m, op, a, 32'($urandom),
                 $urandom_range(0, 59) == 0);
        end

        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drain", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
